// File: rtl/alu_cmd_sequencer.sv
// Request/response front end for the arithmetic unit: latches one operation, issues it,
// waits a fixed latency, captures the result and holds it until the consumer takes it.
module alu_cmd_sequencer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [IN_WIDTH-1:0]  req_a,
    input  logic [IN_WIDTH-1:0]  req_b,
    output logic [IN_WIDTH-1:0]  A,
    output logic [IN_WIDTH-1:0]  B,
    output logic [1:0]           ALU_FUN,
    output logic                 Arith_Enable,
    input  logic [OUT_WIDTH-1:0] Arith_OUT,
    input  logic                 Carry_OUT,
    input  logic                 Arith_Flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_WIDTH-1:0] rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [2:0] LatLoad = 3'(LATENCY);
    localparam logic [1:0] OpDiv   = 2'b11;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]            fun_q, fun_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic                  carry_q, carry_d;
    logic                  err_q, err_d;
    logic [15:0]           count_q, count_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        data_d  = data_q;
        carry_d = carry_q;
        err_d   = err_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    a_d   = req_a;
                    b_d   = req_b;
                    fun_d = req_op;
                    // Divide-by-zero never reaches the unit; answer directly.
                    if (req_op == OpDiv && req_b == '0) begin
                        state_d = StResp;
                        data_d  = '1;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = LatLoad;
            end
            StWait: begin
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                    data_d  = Arith_OUT;
                    carry_d = Carry_OUT;
                    err_d   = ~Arith_Flag;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // req_ready is gated by RST so every output reads 0 while reset is held.
    assign req_ready    = RST && (state_q == StIdle);
    assign Arith_Enable = (state_q == StIssue);
    assign rsp_valid    = (state_q == StResp);
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign rsp_data     = data_q;
    assign rsp_carry    = carry_q;
    assign rsp_err      = err_q;
    assign op_count     = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle registered arithmetic-unit stub.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [7:0]  req_a = 8'd0;
    logic [7:0]  req_b = 8'd0;
    logic [7:0]  A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable;
    logic [15:0] Arith_OUT = 16'd0;
    logic        Carry_OUT = 1'b0;
    logic        Arith_Flag = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;
    logic [15:0] op_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          en_count = 0;
    int          exp_count = 0;
    logic        flag_kill = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .IN_WIDTH (8),
        .OUT_WIDTH(16),
        .LATENCY  (1)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .Arith_Enable(Arith_Enable),
        .Arith_OUT   (Arith_OUT),
        .Carry_OUT   (Carry_OUT),
        .Arith_Flag  (Arith_Flag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_carry   (rsp_carry),
        .rsp_err     (rsp_err),
        .op_count    (op_count)
    );

    // Arithmetic-unit stub: result registered on the enable edge.
    always @(posedge clk) begin
        if (Arith_Enable) begin
            case (ALU_FUN)
                2'b00: {Carry_OUT, Arith_OUT} <= {8'd0, {1'b0, A} + {1'b0, B}};
                2'b01: begin
                    Arith_OUT <= {8'd0, A - B};
                    Carry_OUT <= (A < B);
                end
                2'b10: begin
                    Arith_OUT <= A * B;
                    Carry_OUT <= 1'b0;
                end
                default: begin
                    Arith_OUT <= (B == 8'd0) ? 16'd0 : {8'd0, A / B};
                    Carry_OUT <= 1'b0;
                end
            endcase
            Arith_Flag <= ~flag_kill;
        end
    end

    always @(negedge clk) if (Arith_Enable) en_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_data,
                          input logic exp_carry, input logic exp_err, input int exp_lat,
                          input int exp_en);
        int en0;
        int edges;
        en0 = en_count;
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges = 1;
        check({tag, "_latch"}, {22'd0, ALU_FUN, A, B}, {22'd0, op, a, b});
        check({tag, "_enable"}, 32'(Arith_Enable), 32'(exp_en));
        while (!rsp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_carry_err"}, {30'd0, rsp_carry, rsp_err}, {30'd0, exp_carry, exp_err});
        check({tag, "_en_pulses"}, 32'(en_count - en0), 32'(exp_en));
        @(posedge clk); #1;
        exp_count++;
        check({tag, "_done"}, {14'd0, rsp_valid, req_ready, op_count},
              {14'd0, 1'b0, 1'b1, 16'(exp_count)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_outputs", {6'd0, A, B, ALU_FUN, Arith_Enable, rsp_valid, req_ready},
              32'd0);
        check("reset_rsp", {14'd0, rsp_carry, rsp_err, rsp_data}, 32'd0);
        check("reset_count", 32'(op_count), 0);
        @(negedge clk);
        RST = 1'b1;
        #1;
        check("release_ready", 32'(req_ready), 1);

        run_op("add", 2'b00, 8'd15, 8'd30, 16'd45, 1'b0, 1'b0, 3, 1);
        run_op("sub", 2'b01, 8'd50, 8'd15, 16'd35, 1'b0, 1'b0, 3, 1);
        run_op("mul", 2'b10, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, 3, 1);
        run_op("div0", 2'b11, 8'd50, 8'd0, 16'hFFFF, 1'b0, 1'b1, 1, 0);
        run_op("div", 2'b11, 8'd50, 8'd5, 16'd10, 1'b0, 1'b0, 3, 1);
        run_op("add_carry", 2'b00, 8'd200, 8'd100, 16'd300, 1'b0, 1'b0, 3, 1);
        run_op("sub_borrow", 2'b01, 8'd5, 8'd10, 16'd251, 1'b1, 1'b0, 3, 1);

        // Held response with rsp_ready low.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 8'd255;
        req_b     = 8'd0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_state", {14'd0, rsp_valid, req_ready, rsp_data},
                  {14'd0, 1'b1, 1'b0, 16'd255});
            check("hold_count", 32'(op_count), 32'(exp_count));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        check("hold_release", {15'd0, rsp_valid, op_count}, {15'd0, 1'b0, 16'(exp_count)});

        flag_kill = 1'b1;
        run_op("noflag", 2'b00, 8'd7, 8'd8, 16'd15, 1'b0, 1'b1, 3, 1);
        flag_kill = 1'b0;

        // Reset during WAIT.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 8'd15;
        req_b     = 8'd30;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_wait", {30'd0, Arith_Enable, rsp_valid}, 32'd0);
        RST = 1'b0;
        #1;
        check("midrst_outputs", {6'd0, A, B, ALU_FUN, Arith_Enable, rsp_valid, req_ready},
              32'd0);
        check("midrst_rsp", {14'd0, rsp_carry, rsp_err, rsp_data}, 32'd0);
        check("midrst_count", 32'(op_count), 0);
        @(negedge clk);
        RST = 1'b1;
        exp_count = 0;
        #1;
        check("midrst_ready", 32'(req_ready), 1);
        run_op("post_rst_add", 2'b00, 8'd15, 8'd30, 16'd45, 1'b0, 1'b0, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
